expr_eval: RTL and testbench

- Arithmetic stage downstream of the expression-syntax checker.
- Consumes the same 8-bit ASCII character stream: single digits '0'..'9' joined by '+' and '*'.
- Tracks syntactic validity with its own FSM and evaluates the expression incrementally, with '*' binding tighter than '+'.
- Feeds the result and status flags to the display/compare logic.

---
 rtl/expr_eval.sv | 157 +++++++++++++++
 tb/tb_expr_eval.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_eval.sv
// Incremental evaluator for digit/'+'/'*' ASCII streams; outputs are combinational from state, one-edge latency, no backpressure (in_vld only).
// Optional EXPR_EVAL_MINUS_EN adds '-' with a sign register and two's-complement result/overflow.
module expr_eval #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [7:0]       in,
   input  logic             in_vld,
   output logic [WIDTH-1:0] result,
   output logic             ok,
   output logic             err,
   output logic             ovf
);

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_DIG   = 2'd1,
      ST_OP    = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] term_q, term_d;
   logic             mul_q, mul_d;
   logic             ovf_q, ovf_d;

   logic             is_digit, is_plus, is_star;
   logic [3:0]       dval;
   logic [2*WIDTH-1:0] prod_full;
   logic             prod_ovf;
   logic [WIDTH-1:0] acc_val;
   logic             acc_ovf;

   assign is_digit  = (in >= 8'h30) && (in <= 8'h39);
   assign is_plus   = (in == 8'h2B);
   assign is_star   = (in == 8'h2A);
   assign dval      = in[3:0];
   assign prod_full = {{WIDTH{1'b0}}, term_q} * {{(2*WIDTH-4){1'b0}}, dval};

`ifdef EXPR_EVAL_MINUS_EN
   logic               neg_q, neg_d;
   logic               is_minus;
   logic [WIDTH+1:0]   sum_ext, term_ext, contrib, acc_full;
   logic [2*WIDTH-1:0] mag_lim;

   assign is_minus = (in == 8'h2D);
   // term holds a magnitude; the sign is applied only when it joins the sum
   assign sum_ext  = {{2{sum_q[WIDTH-1]}}, sum_q};
   assign term_ext = {2'b00, term_q};
   assign contrib  = neg_q ? (~term_ext + 1'b1) : term_ext;
   assign acc_full = sum_ext + contrib;
   assign acc_val  = acc_full[WIDTH-1:0];
   assign acc_ovf  = !((acc_full[WIDTH+1:WIDTH-1] == 3'b000) ||
                       (acc_full[WIDTH+1:WIDTH-1] == 3'b111));
   // a negative term may reach exactly 2^(WIDTH-1), a positive one may not
   assign mag_lim  = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
   assign prod_ovf = neg_q ? (prod_full > mag_lim) : (prod_full >= mag_lim);
`else
   logic [WIDTH:0] acc_full;

   assign acc_full = {1'b0, sum_q} + {1'b0, term_q};
   assign acc_val  = acc_full[WIDTH-1:0];
   assign acc_ovf  = acc_full[WIDTH];
   assign prod_ovf = |prod_full[2*WIDTH-1:WIDTH];
`endif

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      term_d  = term_q;
      mul_d   = mul_q;
      ovf_d   = ovf_q;
`ifdef EXPR_EVAL_MINUS_EN
      neg_d   = neg_q;
`endif
      if (in_vld) begin
         case (state_q)
            ST_START: begin
               if (is_digit) begin
                  state_d = ST_DIG;
                  term_d  = {{(WIDTH-4){1'b0}}, dval};
               end else begin
                  state_d = ST_ERR;
               end
            end
            ST_DIG: begin
               if (is_plus) begin
                  state_d = ST_OP;
                  sum_d   = acc_val;
                  mul_d   = 1'b0;
                  ovf_d   = ovf_q | acc_ovf;
`ifdef EXPR_EVAL_MINUS_EN
                  neg_d   = 1'b0;
               end else if (is_minus) begin
                  state_d = ST_OP;
                  sum_d   = acc_val;
                  mul_d   = 1'b0;
                  ovf_d   = ovf_q | acc_ovf;
                  neg_d   = 1'b1;
`endif
               end else if (is_star) begin
                  state_d = ST_OP;
                  mul_d   = 1'b1;
               end else begin
                  state_d = ST_ERR;
               end
            end
            ST_OP: begin
               if (is_digit) begin
                  state_d = ST_DIG;
                  if (mul_q) begin
                     term_d = prod_full[WIDTH-1:0];
                     ovf_d  = ovf_q | prod_ovf;
                  end else begin
                     term_d = {{(WIDTH-4){1'b0}}, dval};
                  end
               end else begin
                  state_d = ST_ERR;
               end
            end
            default: begin
               state_d = ST_ERR;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_START;
         sum_q   <= '0;
         term_q  <= '0;
         mul_q   <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef EXPR_EVAL_MINUS_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         term_q  <= term_d;
         mul_q   <= mul_d;
         ovf_q   <= ovf_d;
`ifdef EXPR_EVAL_MINUS_EN
         neg_q   <= neg_d;
`endif
      end
   end

   assign result = acc_val;
   assign ok     = (state_q == ST_DIG);
   assign err    = (state_q == ST_ERR);
   assign ovf    = ovf_q | acc_ovf;

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval: expected outputs are queued per driven character and checked after the edge.
module tb_expr_eval;

   logic        clk;
   logic        clr;
   logic [7:0]  in;
   logic        in_vld;
   logic [15:0] result;
   logic        ok;
   logic        err;
   logic        ovf;

   typedef struct packed {
      logic [15:0] res;
      logic        ok;
      logic        err;
      logic        ovf;
   } obs_t;

   obs_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   expr_eval #(.WIDTH(16)) dut (
      .clk    (clk),
      .clr    (clr),
      .in     (in),
      .in_vld (in_vld),
      .result (result),
      .ok     (ok),
      .err    (err),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t mk(input logic [15:0] r, input logic o, input logic e, input logic v);
      obs_t x;
      x.res = r; x.ok = o; x.err = e; x.ovf = v;
      return x;
   endfunction

   function automatic obs_t cur();
      obs_t x;
      x.res = result; x.ok = ok; x.err = err; x.ovf = ovf;
      return x;
   endfunction

   function automatic string fmt(input obs_t x);
      return $sformatf("res=%0d ok=%b err=%b ovf=%b", x.res, x.ok, x.err, x.ovf);
   endfunction

   task automatic drive(input logic [7:0] c, input logic vld);
      @(negedge clk);
      in     = c;
      in_vld = vld;
      @(posedge clk);
      #1;
      in_vld = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      #2;
      clr = 1'b0;
   endtask

   task automatic test_reset();
      obs_t got, exp;
      clr = 1'b1; in = 8'h35; in_vld = 1'b1;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(mk(16'd0, 1'b0, 1'b0, 1'b0));
         @(posedge clk); #1;
         got = cur(); exp = exp_q.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL reset[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
         end
      end
      @(negedge clk);
      in_vld = 1'b0;
      clr    = 1'b0;
   endtask

   task automatic test_basic();
      string s = "1+2*3";
      logic [15:0] r[5] = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd7};
      logic        o[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      obs_t got, exp;
      pulse_clr();
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(mk(r[i], o[i], 1'b0, 1'b0));
         drive(s[i], 1'b1);
         got = cur(); exp = exp_q.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL basic[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
         end
      end
   endtask

   task automatic test_gaps();
      string s = "2*3*4+5";
      logic [15:0] r[7] = '{16'd2, 16'd2, 16'd6, 16'd6, 16'd24, 16'd48, 16'd29};
      logic        o[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      obs_t got, exp;
      pulse_clr();
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(mk(r[i], o[i], 1'b0, 1'b0));
         drive(s[i], 1'b1);
         got = cur(); exp = exp_q.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL gaps[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
         end
         // idle cycles carry a bad character that must be ignored
         for (int g = 0; g < 2; g++) begin
            exp_q.push_back(mk(r[i], o[i], 1'b0, 1'b0));
            drive(8'h61, 1'b0);
            got = cur(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin
               n_bad++;
               $display("FAIL gaps_idle[%0d.%0d]: got %s, expected %s", i, g, fmt(got), fmt(exp));
            end
         end
      end
   endtask

   task automatic test_err_sticky();
      string s = "+13";
      obs_t got, exp;
      pulse_clr();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mk(16'd0, 1'b0, 1'b1, 1'b0));
         drive(s[i], 1'b1);
         got = cur(); exp = exp_q.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL err_sticky[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
         end
      end
   endtask

   task automatic test_bad_and_async_clr();
      string s1 = "12";
      string s2 = "7a";
      obs_t got, exp;
      pulse_clr();
      exp_q.push_back(mk(16'd1, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(16'd1, 1'b0, 1'b1, 1'b0));
      for (int i = 0; i < 2; i++) begin
         drive(s1[i], 1'b1);
         got = cur(); exp = exp_q.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL two_digit[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
         end
      end
      pulse_clr();
      exp_q.push_back(mk(16'd7, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(16'd7, 1'b0, 1'b1, 1'b0));
      for (int i = 0; i < 2; i++) begin
         drive(s2[i], 1'b1);
         got = cur(); exp = exp_q.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL bad_char[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
         end
      end
      // clr raised between clock edges must clear outputs without an edge
      @(posedge clk);
      #3 clr = 1'b1;
      exp_q.push_back(mk(16'd0, 1'b0, 1'b0, 1'b0));
      #1;
      got = cur(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL async_clr: got %s, expected %s", fmt(got), fmt(exp));
      end
      #2 clr = 1'b0;
      exp_q.push_back(mk(16'd4, 1'b1, 1'b0, 1'b0));
      drive(8'h34, 1'b1);
      got = cur(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL after_clr: got %s, expected %s", fmt(got), fmt(exp));
      end
   endtask

   task automatic test_overflow();
      string s = "9*9*9*9*9*9+1";
      logic [15:0] r[13] = '{16'd9, 16'd9, 16'd81, 16'd81, 16'd729, 16'd729, 16'd6561,
                             16'd6561, 16'd59049, 16'd59049, 16'd7153, 16'd14306, 16'd7154};
      obs_t got, exp;
      pulse_clr();
      for (int i = 0; i < 13; i++) begin
         exp_q.push_back(mk(r[i], (i % 2) == 0, 1'b0, i >= 10));
         drive(s[i], 1'b1);
         got = cur(); exp = exp_q.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL overflow[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
         end
      end
   endtask

   task automatic test_mul_zero();
      string s = "5*0";
      logic [15:0] r[3] = '{16'd5, 16'd5, 16'd0};
      logic        o[3] = '{1'b1, 1'b0, 1'b1};
      obs_t got, exp;
      pulse_clr();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mk(r[i], o[i], 1'b0, 1'b0));
         drive(s[i], 1'b1);
         got = cur(); exp = exp_q.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL mul_zero[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
         end
      end
   endtask

   task automatic test_minus();
      string s = "3-4*2";
`ifdef EXPR_EVAL_MINUS_EN
      logic [15:0] r[5] = '{16'd3, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFB};
      logic        o[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic        e[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
      logic [15:0] r[5] = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd3};
      logic        o[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        e[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
      obs_t got, exp;
      pulse_clr();
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(mk(r[i], o[i], e[i], 1'b0));
         drive(s[i], 1'b1);
         got = cur(); exp = exp_q.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL minus[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
         end
      end
   endtask

   initial begin
      clr    = 1'b1;
      in     = 8'h00;
      in_vld = 1'b0;
      test_reset();
      test_basic();
      test_gaps();
      test_err_sticky();
      test_bad_and_async_clr();
      test_overflow();
      test_mul_zero();
      test_minus();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
